// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative multiply/divide unit (MUL, SMULH, SDIV, UDIV) with a
// start/busy/done handshake. Multiply is shift-add and divide is restoring
// division, one bit per cycle for WIDTH cycles, on sign-stripped magnitudes.
// The sign is restored in a single step as the result is registered.
// Optional build macro: MULDIV_ZERO_SKIP_EN. When it is defined, a zero divisor
// or multiplier (any op), or a zero multiplicand (MUL/SMULH), skips from PREP
// straight to DONE.
//
// state | meaning
// IDLE  | waiting for start; latches op and operands on start
// PREP  | takes operand magnitudes and signs, clears the accumulator, loads the counter
// RUN   | WIDTH iterations, counter WIDTH-1 down to 0
// DONE  | one-cycle done pulse; result and divByZero already registered
module muldiv_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] operandA,
  input  logic [WIDTH-1:0] operandB,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             divByZero
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {S_IDLE, S_PREP, S_RUN, S_DONE} state_t;

  state_t             state, state_nxt;
  logic [1:0]         op_q;
  logic [WIDTH-1:0]   a_q, b_q;
  logic [WIDTH-1:0]   opnd_q;
  logic [2*WIDTH-1:0] prod;
  logic [CW-1:0]      cnt;
  logic               neg_q;

  logic               is_div, is_signed, b_zero, skip;
  logic [WIDTH-1:0]   a_mag, b_mag;
  logic [WIDTH:0]     mul_sum, div_sh, div_diff;
  logic [2*WIDTH-1:0] prod_step, prod_fix;
  logic [WIDTH-1:0]   res_final;

  assign is_div    = op_q[1];
  assign is_signed = (op_q != 2'b11);
  assign b_zero    = (b_q == '0);
  assign busy      = (state != S_IDLE);
  assign done      = (state == S_DONE);

`ifdef MULDIV_ZERO_SKIP_EN
  assign skip = b_zero || (!is_div && (a_q == '0));
`else
  assign skip = 1'b0;
`endif

  // State register.
  always_ff @(posedge clk) begin
    if (reset) state <= S_IDLE;
    else       state <= state_nxt;
  end

  // Next-state logic.
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (start) state_nxt = S_PREP;
      S_PREP:  state_nxt = skip ? S_DONE : S_RUN;
      S_RUN:   if (cnt == '0) state_nxt = S_DONE;
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Magnitudes (the most-negative value maps to 2^(WIDTH-1) as unsigned).
  always_comb begin
    a_mag = (is_signed && a_q[WIDTH-1]) ? (~a_q + 1'b1) : a_q;
    b_mag = (is_signed && b_q[WIDTH-1]) ? (~b_q + 1'b1) : b_q;
  end

  // One iteration step and the sign-corrected final value it produces.
  always_comb begin
    mul_sum  = {1'b0, prod[2*WIDTH-1:WIDTH]} + (prod[0] ? {1'b0, opnd_q} : '0);
    div_sh   = prod[2*WIDTH-1:WIDTH-1];
    div_diff = div_sh - {1'b0, opnd_q};
    prod_step = prod;
    if (is_div) begin
      if (div_diff[WIDTH]) prod_step = {div_sh[WIDTH-1:0], prod[WIDTH-2:0], 1'b0};
      else                 prod_step = {div_diff[WIDTH-1:0], prod[WIDTH-2:0], 1'b1};
    end else begin
      prod_step = {mul_sum, prod[WIDTH-1:1]};
    end
    prod_fix = neg_q ? (~prod_step + 1'b1) : prod_step;
    res_final = (op_q == 2'b01) ? prod_fix[2*WIDTH-1:WIDTH] : prod_fix[WIDTH-1:0];
    if (is_div && b_zero) res_final = '0;
  end

  // Operand capture, iteration datapath and registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      op_q      <= '0;
      a_q       <= '0;
      b_q       <= '0;
      opnd_q    <= '0;
      prod      <= '0;
      cnt       <= '0;
      neg_q     <= 1'b0;
      result    <= '0;
      divByZero <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            op_q <= op;
            a_q  <= operandA;
            b_q  <= operandB;
          end
        end
        S_PREP: begin
          neg_q  <= is_signed && (a_q[WIDTH-1] ^ b_q[WIDTH-1]);
          cnt    <= CW'(WIDTH-1);
          opnd_q <= is_div ? b_mag : a_mag;
          prod   <= {{WIDTH{1'b0}}, (is_div ? a_mag : b_mag)};
`ifdef MULDIV_ZERO_SKIP_EN
          if (skip) begin
            result    <= '0;
            divByZero <= is_div && b_zero;
          end
`endif
        end
        S_RUN: begin
          prod <= prod_step;
          cnt  <= cnt - 1'b1;
          if (cnt == '0) begin
            result    <= res_final;
            divByZero <= is_div && b_zero;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit (WIDTH=32): hand-written vector table,
// randomized operations against an arithmetic reference model, and handshake,
// reset-abort and hold sequences. Honors MULDIV_ZERO_SKIP_EN for latency.
module tb_muldiv_unit;
  localparam int W = 32;

  logic          clk = 1'b0;
  logic          reset, start;
  logic [1:0]    op;
  logic [W-1:0]  operandA, operandB;
  logic          busy, done, divByZero;
  logic [W-1:0]  result;

  int total = 0;
  int passed = 0;

  muldiv_unit #(.WIDTH(W)) dut (
    .clk(clk), .reset(reset), .start(start), .op(op),
    .operandA(operandA), .operandB(operandB),
    .busy(busy), .done(done), .result(result), .divByZero(divByZero)
  );

  always #5 clk = ~clk;

  initial begin
    #600000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  typedef struct {
    string      name;
    logic [1:0] op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] res;
    logic       dbz;
  } vec_t;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h", nm, act, exp);
  endtask

  // Reference: plain 64-bit arithmetic.
  function automatic void model(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                                output logic [31:0] r, output logic z);
    logic [63:0] p;
    longint sa, sb;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    z = 1'b0;
    r = '0;
    case (o)
      2'b00: begin p = {32'd0, a} * {32'd0, b}; r = p[31:0]; end
      2'b01: begin p = sa * sb; r = p[63:32]; end
      2'b10: if (b == 0) z = 1'b1; else begin p = sa / sb; r = p[31:0]; end
      default: if (b == 0) z = 1'b1; else r = a / b;
    endcase
  endfunction

  // Edges from the edge before start is driven to the first cycle with done high.
  function automatic int exp_lat(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
`ifdef MULDIV_ZERO_SKIP_EN
    if (b == 0 || (!o[1] && a == 0)) return 2;
`endif
    return W + 2;
  endfunction

  task automatic wait_idle();
    for (int i = 0; i < 100 && busy; i++) @(negedge clk);
    if (busy) check("wait_idle_timeout", 32'(busy), 32'd0);
  endtask

  task automatic do_op(input string nm, input logic [1:0] o, input logic [31:0] a,
                       input logic [31:0] b, input logic [31:0] er, input logic ez);
    int k;
    int lat;
    lat = exp_lat(o, a, b);
    wait_idle();
    @(negedge clk);
    start = 1'b1; op = o; operandA = a; operandB = b;
    @(negedge clk);
    k = 1;
    check({nm, "_busy"}, 32'(busy), 32'd1);
    start = 1'b0; op = 2'($urandom); operandA = $urandom; operandB = $urandom;
    while (!done && k < W + 12) begin
      @(negedge clk);
      k++;
    end
    check({nm, "_latency"}, 32'(k), 32'(lat));
    check({nm, "_result"}, result, er);
    check({nm, "_dbz"}, 32'(divByZero), 32'(ez));
    @(negedge clk);
    check({nm, "_done_pulse"}, {30'd0, busy, done}, 32'd0);
  endtask

  task automatic hold_check(input string nm, input logic [31:0] er, input logic ez);
    int bad = 0;
    for (int i = 0; i < 10; i++) begin
      operandA = $urandom; operandB = $urandom; op = 2'($urandom);
      @(negedge clk);
      if (result !== er || divByZero !== ez || busy !== 1'b0 || done !== 1'b0) bad++;
    end
    check({nm, "_hold_bad_cycles"}, 32'(bad), 32'd0);
    check({nm, "_hold_result"}, result, er);
  endtask

  vec_t vecs[$];

  initial begin
    logic [31:0] er;
    logic        ez;
    int          k;
    int          dcount;
    int          dtimes[4];
    int          seen;

    vecs.push_back('{"mul_7_m3",      2'b00, 32'd7,          32'hFFFFFFFD, 32'hFFFFFFEB, 1'b0});
    vecs.push_back('{"smulh_min_2",   2'b01, 32'h80000000,   32'd2,        32'hFFFFFFFF, 1'b0});
    vecs.push_back('{"sdiv_m7_2",     2'b10, 32'hFFFFFFF9,   32'd2,        32'hFFFFFFFD, 1'b0});
    vecs.push_back('{"sdiv_min_m1",   2'b10, 32'h80000000,   32'hFFFFFFFF, 32'h80000000, 1'b0});
    vecs.push_back('{"udiv_max_16",   2'b11, 32'hFFFFFFFF,   32'd16,       32'h0FFFFFFF, 1'b0});
    vecs.push_back('{"udiv_5_0",      2'b11, 32'd5,          32'd0,        32'h00000000, 1'b1});
    vecs.push_back('{"sdiv_m5_0",     2'b10, 32'hFFFFFFFB,   32'd0,        32'h00000000, 1'b1});
    vecs.push_back('{"sdiv_7_m2",     2'b10, 32'd7,          32'hFFFFFFFE, 32'hFFFFFFFD, 1'b0});
    vecs.push_back('{"smulh_m1_m1",   2'b01, 32'hFFFFFFFF,   32'hFFFFFFFF, 32'h00000000, 1'b0});
    vecs.push_back('{"smulh_max_max", 2'b01, 32'h7FFFFFFF,   32'h7FFFFFFF, 32'h3FFFFFFF, 1'b0});
    vecs.push_back('{"smulh_64k_64k", 2'b01, 32'h00010000,   32'h00010000, 32'h00000001, 1'b0});
    vecs.push_back('{"mul_64k_64k",   2'b00, 32'h00010000,   32'h00010000, 32'h00000000, 1'b0});
    vecs.push_back('{"mul_0_5",       2'b00, 32'd0,          32'd5,        32'h00000000, 1'b0});
    vecs.push_back('{"mul_ff_0",      2'b00, 32'hFF,         32'd0,        32'h00000000, 1'b0});
    vecs.push_back('{"udiv_100_7",    2'b11, 32'd100,        32'd7,        32'd14,       1'b0});

    reset = 1'b1; start = 1'b0; op = 2'b00; operandA = '0; operandB = '0;
    repeat (2) @(negedge clk);
    check("reset_busy", 32'(busy), 32'd0);
    check("reset_done", 32'(done), 32'd0);
    check("reset_result", result, 32'd0);
    check("reset_dbz", 32'(divByZero), 32'd0);
    reset = 1'b0;
    @(negedge clk);

    foreach (vecs[i]) do_op(vecs[i].name, vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].res, vecs[i].dbz);

    // Randomized operations against the model.
    for (int i = 0; i < 40; i++) begin
      logic [1:0]  ro;
      logic [31:0] ra, rb;
      ro = 2'($urandom);
      case ($urandom_range(0, 7))
        0: ra = 32'd0;
        1: ra = 32'h80000000;
        2: ra = $urandom_range(0, 20);
        default: ra = $urandom;
      endcase
      case ($urandom_range(0, 7))
        0: rb = 32'd0;
        1: rb = 32'hFFFFFFFF;
        2: rb = $urandom_range(1, 20);
        default: rb = $urandom;
      endcase
      model(ro, ra, rb, er, ez);
      do_op($sformatf("rand%0d", i), ro, ra, rb, er, ez);
    end

    // Hold after completion.
    do_op("hold_sdiv", 2'b10, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFD, 1'b0);
    hold_check("sdiv", 32'hFFFFFFFD, 1'b0);
    do_op("hold_udiv0", 2'b11, 32'd5, 32'd0, 32'd0, 1'b1);
    hold_check("udiv0", 32'd0, 1'b1);

    // Start pulsed during RUN is ignored and not queued.
    wait_idle();
    @(negedge clk);
    start = 1'b1; op = 2'b00; operandA = 32'd7; operandB = 32'hFFFFFFFD;
    @(negedge clk);
    k = 1;
    start = 1'b0;
    for (; k < 10; k++) @(negedge clk);
    start = 1'b1; op = 2'b11; operandA = 32'd100; operandB = 32'd3;
    @(negedge clk);
    k++;
    start = 1'b0;
    while (!done && k < W + 12) begin
      @(negedge clk);
      k++;
    end
    check("ignore_latency", 32'(k), 32'(W + 2));
    check("ignore_result", result, 32'hFFFFFFEB);
    seen = 0;
    for (int i = 0; i < 45; i++) begin
      @(negedge clk);
      if (done) seen++;
    end
    check("ignore_no_queued_done", 32'(seen), 32'd0);

    // Back-to-back with start held high.
    @(negedge clk);
    start = 1'b1; op = 2'b00; operandA = 32'd3; operandB = 32'd5;
    dcount = 0;
    for (int c = 1; c <= 200 && dcount < 4; c++) begin
      @(negedge clk);
      if (done) begin
        dtimes[dcount] = c;
        dcount++;
      end
    end
    start = 1'b0;
    check("b2b_done_count", 32'(dcount), 32'd4);
    check("b2b_first_latency", 32'(dtimes[0]), 32'(W + 2));
    for (int i = 1; i < 4; i++) check($sformatf("b2b_interval%0d", i), 32'(dtimes[i] - dtimes[i-1]), 32'(W + 3));
    check("b2b_result", result, 32'd15);
    wait_idle();

    // Reset mid-RUN aborts with no done.
    do_op("pre_reset_mul", 2'b00, 32'd7, 32'hFFFFFFFD, 32'hFFFFFFEB, 1'b0);
    @(negedge clk);
    start = 1'b1; op = 2'b01; operandA = 32'h12345; operandB = 32'h6789;
    @(negedge clk);
    start = 1'b0;
    repeat (10) @(negedge clk);
    check("abort_busy_before", 32'(busy), 32'd1);
    reset = 1'b1;
    @(negedge clk);
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_done", 32'(done), 32'd0);
    check("abort_result", result, 32'd0);
    check("abort_dbz", 32'(divByZero), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    seen = 0;
    for (int i = 0; i < 45; i++) begin
      @(negedge clk);
      if (done || busy) seen++;
    end
    check("abort_no_done", 32'(seen), 32'd0);
    do_op("post_reset_udiv", 2'b11, 32'hFFFFFFFF, 32'd16, 32'h0FFFFFFF, 1'b0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
